// File: rtl/conv_ctrl_pkg.sv
// Shared types and sizing helpers for the convolution window controller.
package conv_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Counter width for a modulo-n count; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Number of stride-aligned window positions along one axis.
   function automatic int out_dim(input int img, input int k, input int s);
      return (img - k) / s + 1;
   endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N up counter with synchronous clear and a terminal-count flag.
module wrap_counter
   import conv_ctrl_pkg::*;
#(
   parameter int N = 4,
   localparam int W = cnt_w(N)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         wrap_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign wrap_o = (cnt_q == W'(N - 1));
   assign cnt_o  = cnt_q;

   // Clear wins over increment; increment rolls over at N-1.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/conv_window_ctrl.sv
// Frame sequencer for the convolution front end: accepts a raster pixel
// stream, drives the line-buffer shift enable and flags stride-aligned
// complete KxK windows with their output-map coordinates.
module conv_window_ctrl
   import conv_ctrl_pkg::*;
#(
   parameter int IMG_WIDTH  = 28,
   parameter int IMG_HEIGHT = 28,
   parameter int KERNEL     = 5,
   parameter int STRIDE     = 1,
   localparam int OUT_W     = out_dim(IMG_WIDTH, KERNEL, STRIDE),
   localparam int OUT_H     = out_dim(IMG_HEIGHT, KERNEL, STRIDE),
   localparam int OCOL_W    = cnt_w(OUT_W),
   localparam int OROW_W    = cnt_w(OUT_H)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              lb_en,
   output logic              win_valid,
   input  logic              win_ready,
   output logic [OROW_W-1:0] out_row,
   output logic [OCOL_W-1:0] out_col,
   output logic              frame_done
);

   localparam int COL_W = cnt_w(IMG_WIDTH);
   localparam int ROW_W = cnt_w(IMG_HEIGHT);
   localparam int PH_W  = cnt_w(STRIDE);
   localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KERNEL - 1);
   localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(KERNEL - 1);

   state_e state_q;
   state_e state_d;
   logic   win_valid_q;
   logic   win_valid_d;

   logic             start_go;
   logic             consume;
   logic             complete;
   logic             last_px;
   logic             col_at_k;
   logic             row_at_k;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [PH_W-1:0]  col_ph;
   logic [PH_W-1:0]  row_ph;
   logic             col_wrap;
   logic             row_wrap;
   logic             col_ph_wrap_unused;
   logic             row_ph_wrap_unused;
   logic             out_col_wrap;
   logic             out_row_wrap_unused;

   assign start_go = (state_q == ST_IDLE) && start;
   assign consume  = win_valid_q && win_ready;
   // One-deep window slot: a new pixel may only shift in if the slot is
   // empty or being drained this cycle.
   assign in_ready = (state_q == ST_RUN) && (!win_valid_q || win_ready);
   assign lb_en    = in_valid && in_ready;
   assign col_at_k = (col >= COL_FIRST);
   assign row_at_k = (row >= ROW_FIRST);
   assign last_px  = col_wrap && row_wrap;
   assign complete = lb_en && row_at_k && col_at_k &&
                     (row_ph == '0) && (col_ph == '0);

   assign busy       = (state_q != ST_IDLE);
   assign frame_done = (state_q == ST_DONE);
   assign win_valid  = win_valid_q;

   wrap_counter #(.N(IMG_WIDTH)) u_col (
      .clk(clk), .reset(reset), .clr_i(start_go), .en_i(lb_en),
      .cnt_o(col), .wrap_o(col_wrap)
   );

   wrap_counter #(.N(IMG_HEIGHT)) u_row (
      .clk(clk), .reset(reset), .clr_i(start_go), .en_i(lb_en && col_wrap),
      .cnt_o(row), .wrap_o(row_wrap)
   );

   // Column phase restarts every row so column K-1 is always phase 0.
   wrap_counter #(.N(STRIDE)) u_col_ph (
      .clk(clk), .reset(reset), .clr_i(start_go || (lb_en && col_wrap)),
      .en_i(lb_en && col_at_k),
      .cnt_o(col_ph), .wrap_o(col_ph_wrap_unused)
   );

   // Row phase steps once per completed row from row K-1 onward.
   wrap_counter #(.N(STRIDE)) u_row_ph (
      .clk(clk), .reset(reset), .clr_i(start_go),
      .en_i(lb_en && col_wrap && row_at_k),
      .cnt_o(row_ph), .wrap_o(row_ph_wrap_unused)
   );

   wrap_counter #(.N(OUT_W)) u_out_col (
      .clk(clk), .reset(reset), .clr_i(start_go), .en_i(consume),
      .cnt_o(out_col), .wrap_o(out_col_wrap)
   );

   wrap_counter #(.N(OUT_H)) u_out_row (
      .clk(clk), .reset(reset), .clr_i(start_go), .en_i(consume && out_col_wrap),
      .cnt_o(out_row), .wrap_o(out_row_wrap_unused)
   );

   // Window slot: a completing accept fills it even while it is drained.
   always_comb begin
      win_valid_d = win_valid_q;
      if (complete) begin
         win_valid_d = 1'b1;
      end else if (consume) begin
         win_valid_d = 1'b0;
      end
   end

   // Frame sequencing: stream, drain the last window, then pulse done.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = ST_RUN;
         ST_RUN:   if (lb_en && last_px) state_d = ST_FLUSH;
         ST_FLUSH: if (!win_valid_q || win_ready) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State and window-slot registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         win_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_valid_q <= win_valid_d;
      end
   end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench: a stride-1 and a stride-2 controller share one random
// stimulus stream; a frame-level reference model predicts each window.
module tb_conv_window_ctrl;

   localparam int IMG = 28;
   localparam int K   = 5;
   localparam int NPX = IMG * IMG;

   logic       clk = 1'b0;
   logic       reset, start, in_valid, win_ready;
   logic [1:0] busy, in_ready, lb_en, win_valid, frame_done;
   logic [4:0] orow0, ocol0;
   logic [3:0] orow1, ocol1;

   int total = 0;
   int bad   = 0;
   int mph    [2];
   int px     [2];
   int wins   [2];
   int frames [2];
   bit ewv    [2];
   int q0 [$];
   int q1 [$];
   int to_cnt;
   bit fin;
   bit fin_done = 1'b0;

   always #5 clk = ~clk;

   conv_window_ctrl #(.IMG_WIDTH(IMG), .IMG_HEIGHT(IMG), .KERNEL(K), .STRIDE(1)) dut0 (
      .clk(clk), .reset(reset), .start(start), .busy(busy[0]),
      .in_valid(in_valid), .in_ready(in_ready[0]), .lb_en(lb_en[0]),
      .win_valid(win_valid[0]), .win_ready(win_ready),
      .out_row(orow0), .out_col(ocol0), .frame_done(frame_done[0])
   );

   conv_window_ctrl #(.IMG_WIDTH(IMG), .IMG_HEIGHT(IMG), .KERNEL(K), .STRIDE(2)) dut1 (
      .clk(clk), .reset(reset), .start(start), .busy(busy[1]),
      .in_valid(in_valid), .in_ready(in_ready[1]), .lb_en(lb_en[1]),
      .win_valid(win_valid[1]), .win_ready(win_ready),
      .out_row(orow1), .out_col(ocol1), .frame_done(frame_done[1])
   );

   function automatic int strd(input int i);
      return (i == 0) ? 1 : 2;
   endfunction

   function automatic int nwin(input int i);
      int o;
      o = (IMG - K) / strd(i) + 1;
      return o * o;
   endfunction

   task automatic chk(input string nm, input int inst, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s[%0d] t=%0t: got %0d, expected %0d", nm, inst, $time, act, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         mph[i] = 0; px[i] = 0; wins[i] = 0; frames[i] = 0; ewv[i] = 1'b0;
      end
   end

   // Monitor + reference model: phases 0 idle, 1 streaming, 2 draining, 3 done.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         bit ire, acc, comp, nwv;
         int r, c, s, pos, e, nm;
         s   = strd(i);
         pos = (i == 0) ? (int'(orow0) * 256 + int'(ocol0)) : (int'(orow1) * 256 + int'(ocol1));
         ire = (mph[i] == 1) && (!ewv[i] || win_ready);
         chk("busy",       i, int'(busy[i]),       int'(mph[i] != 0));
         chk("in_ready",   i, int'(in_ready[i]),   int'(ire));
         chk("lb_en",      i, int'(lb_en[i]),      int'(in_valid && ire));
         chk("win_valid",  i, int'(win_valid[i]),  int'(ewv[i]));
         chk("frame_done", i, int'(frame_done[i]), int'(mph[i] == 3));
         if (lb_en[i]) chk("accept_while_pending", i, int'(win_valid[i] && !win_ready), 0);
         if (mph[i] == 0) chk("idle_out_pos", i, pos, 0);
         if (ewv[i] && win_ready) begin
            if ((i == 0 ? q0.size() : q1.size()) == 0) begin
               chk("window_unexpected", i, 1, 0);
            end else begin
               e = (i == 0) ? q0.pop_front() : q1.pop_front();
               chk("out_pos", i, pos, e);
            end
            wins[i]++;
         end
         if (mph[i] == 3) begin
            frames[i]++;
            chk("frame_windows", i, wins[i], nwin(i));
            chk("frame_pixels",  i, px[i], NPX);
         end
         acc  = ire && in_valid;
         comp = 1'b0;
         if (acc) begin
            r = px[i] / IMG;
            c = px[i] % IMG;
            comp = (r >= K - 1) && (c >= K - 1) && ((r - (K - 1)) % s == 0) && ((c - (K - 1)) % s == 0);
            if (comp) begin
               e = ((r - (K - 1)) / s) * 256 + (c - (K - 1)) / s;
               if (i == 0) q0.push_back(e); else q1.push_back(e);
            end
            px[i]++;
         end
         nwv = comp ? 1'b1 : ((ewv[i] && win_ready) ? 1'b0 : ewv[i]);
         nm  = mph[i];
         case (mph[i])
            0: if (start) begin nm = 1; px[i] = 0; wins[i] = 0; end
            1: if (acc && px[i] == NPX) nm = 2;
            2: if (!ewv[i] || win_ready) nm = 3;
            default: nm = 0;
         endcase
         if (reset) begin
            nm = 0; nwv = 1'b0; px[i] = 0; wins[i] = 0;
            if (i == 0) q0.delete(); else q1.delete();
         end
         mph[i] = nm;
         ewv[i] = nwv;
      end
      if (fin && !fin_done) begin
         chk("frames_completed", 0, frames[0], 4);
         chk("frames_completed", 1, frames[1], 4);
         chk("timeouts", 0, to_cnt, 0);
         fin_done = 1'b1;
      end
   end

   task automatic drive(input bit rnd, input bit hold);
      in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      win_ready = hold ? 1'b0 : (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
   endtask

   task automatic run_frame(input bit rnd, input bit bp, input bit midstart);
      int f0, f1, n, held;
      bit hold;
      f0 = frames[0];
      f1 = frames[1];
      start = 1'b1;
      drive(rnd, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      held = 0;
      while (!(frames[0] > f0 && frames[1] > f1) && n < 20000) begin
         hold = 1'b0;
         if (bp && held < 10 && (held > 0 || win_valid[0])) begin
            hold = 1'b1;
            held++;
         end
         start = midstart && (n == 200);
         drive(rnd, hold);
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20000) to_cnt++;
      start = 1'b0;
      in_valid = 1'b0;
      win_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; win_ready = 1'b0;
      fin = 1'b0; to_cnt = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      run_frame(1'b0, 1'b0, 1'b0);
      run_frame(1'b0, 1'b1, 1'b1);
      run_frame(1'b1, 1'b0, 1'b0);
      // Aborted frame: reset once roughly 300 pixels have streamed in.
      start = 1'b1;
      drive(1'b1, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (px[0] < 300 && n < 5000) begin
         drive(1'b1, 1'b0);
         @(posedge clk); #1;
         n++;
      end
      if (n >= 5000) to_cnt++;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      run_frame(1'b1, 1'b0, 1'b0);
      fin = 1'b1;
      n = 0;
      while (!fin_done && n < 10) begin
         @(posedge clk);
         n++;
      end
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
